// File: rtl/soc_pio_ext.sv
// Parametrised Avalon-MM PIO slave: set/clear output register, synchronised input,
// edge capture with level interrupt. Optional BLINK register behind SOC_PIO_EXT_BLINK_EN.
module soc_pio_ext #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [2:0] AddrData    = 3'd0;
  localparam logic [2:0] AddrOut     = 3'd1;
  localparam logic [2:0] AddrIrqMask = 3'd2;
  localparam logic [2:0] AddrEdgeCap = 3'd3;
  localparam logic [2:0] AddrOutSet  = 3'd4;
  localparam logic [2:0] AddrOutClr  = 3'd5;
`ifdef SOC_PIO_EXT_BLINK_EN
  localparam logic [2:0] AddrBlink   = 3'd6;
`endif

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [DATA_WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [DATA_WIDTH-1:0] edge_det;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] rd_data;

  // Reads have no side effects, so the read strobe and upper write bits go unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, read_n, writedata};

  assign wr_en = chipselect && !write_n;
  assign wdata = writedata[DATA_WIDTH-1:0];

  always_comb begin
    case (EDGE_TYPE)
      1:       edge_det = ~s2_q & s3_q;
      2:       edge_det = s2_q ^ s3_q;
      default: edge_det = s2_q & ~s3_q;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    if (wr_en) begin
      case (address)
        AddrData, AddrOut: data_out_d = wdata;
        AddrIrqMask:       irq_mask_d = wdata;
        AddrEdgeCap:       edge_cap_d = edge_cap_q & ~wdata;
        AddrOutSet:        data_out_d = data_out_q | wdata;
        AddrOutClr:        data_out_d = data_out_q & ~wdata;
        default:           ;
      endcase
    end
    // A fresh edge is OR-ed in after the clear so it survives a same-cycle W1C.
    edge_cap_d = edge_cap_d | edge_det;
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the synchroniser chain shifts by one stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      s1_q       <= in_port;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

`ifdef SOC_PIO_EXT_BLINK_EN
`ifndef SOC_PIO_EXT_BLINK_BITS
`define SOC_PIO_EXT_BLINK_BITS 24
`endif
  localparam int BlinkBits = `SOC_PIO_EXT_BLINK_BITS;

  logic [BlinkBits-1:0]  presc_q;
  logic                  toggle_q;
  logic [DATA_WIDTH-1:0] blink_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      toggle_q <= 1'b0;
      blink_q  <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (&presc_q) toggle_q <= ~toggle_q;
      if (wr_en && address == AddrBlink) blink_q <= wdata;
    end
  end

  assign out_port = data_out_q ^ (blink_q & {DATA_WIDTH{toggle_q}});
`else
  assign out_port = data_out_q;
`endif

  always_comb begin
    rd_data = '0;
    case (address)
      AddrData:    rd_data = s2_q;
      AddrOut:     rd_data = data_out_q;
      AddrIrqMask: rd_data = irq_mask_q;
      AddrEdgeCap: rd_data = edge_cap_q;
`ifdef SOC_PIO_EXT_BLINK_EN
      AddrBlink:   rd_data = blink_q;
`endif
      default:     rd_data = '0;
    endcase
  end

  assign readdata = 32'(rd_data);

endmodule
